// File: rtl/rtc_ts_capture.sv
// rtc_ts_capture: samples an asynchronous event line, captures the RTC time on
// qualifying edges, removes the fixed capture-path latency (with seconds
// borrow), and queues the results in a show-ahead FIFO.
module rtc_ts_capture #(
  parameter int          DEPTH     = 16,
  parameter int          ADDR_W    = 4,
  parameter logic [37:0] TS_COMP   = 38'd768,
  parameter logic [37:0] TS_MODULO = 38'd256000000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [37:0]       rtc_ns,
  input  logic [47:0]       rtc_sec,
  input  logic              event_in,
  input  logic              cap_en,
  input  logic [1:0]        edge_sel,
  input  logic              rd_en,
  input  logic              ovf_clr,
  output logic              ts_valid,
  output logic [37:0]       ts_ns,
  output logic [47:0]       ts_sec,
  output logic [ADDR_W:0]   ts_cnt,
  output logic              ts_ovf
);

  typedef struct packed {
    logic [47:0] sec;
    logic [37:0] ns;
  } ts_t;

  // Amount added when the compensation borrows one second; always fits in 38 bits.
  localparam logic [37:0]       BORROW_ADD = TS_MODULO - TS_COMP;
  localparam logic [ADDR_W:0]   FULL_CNT   = (ADDR_W+1)'(DEPTH);

  logic            sync0, ev_s, ev_d;
  logic            rise, fall, hit;
  logic [1:0]      vld_pipe;  // [0]=cap_vld (S3), [1]=comp_vld (S4)
  ts_t             cap, comp, head;
  ts_t             mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0] cnt;
  logic            full, pop, push, drop, ovf;

  // Two-flop synchronizer plus previous-value register for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      ev_s  <= 1'b0;
      ev_d  <= 1'b0;
    end else begin
      sync0 <= event_in;
      ev_s  <= sync0;
      ev_d  <= ev_s;
    end
  end

  // Edge qualification against the selected polarity; 11 disables capture.
  always_comb begin
    rise = ev_s & ~ev_d;
    fall = ~ev_s & ev_d;
    hit  = 1'b0;
    unique case (edge_sel)
      2'b00:   hit = rise;
      2'b01:   hit = fall;
      2'b10:   hit = rise | fall;
      default: hit = 1'b0;
    endcase
    hit = hit & cap_en;
  end

  // Valid bits follow each capture through compensation into the FIFO write.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[0], hit};
  end

  // Capture RTC time on a qualifying edge (data path needs no reset).
  always_ff @(posedge clk) begin
    if (hit) cap <= '{sec: rtc_sec, ns: rtc_ns};
  end

  // Subtract the latency; borrow a second when the ns field would go negative.
  always_ff @(posedge clk) begin
    if (vld_pipe[0]) begin
      if (cap.ns >= TS_COMP) begin
        comp.ns  <= cap.ns - TS_COMP;
        comp.sec <= cap.sec;
      end else begin
        comp.ns  <= cap.ns + BORROW_ADD;
        comp.sec <= cap.sec - 48'd1;
      end
    end
  end

  // FIFO control: a pop frees the slot for a same-cycle write even when full.
  always_comb begin
    full = (cnt == FULL_CNT);
    pop  = rd_en & (cnt != '0);
    push = vld_pipe[1] & (~full | pop);
    drop = vld_pipe[1] & full & ~pop;
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= comp;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky overflow; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // Show-ahead outputs, forced to zero while empty.
  always_comb begin
    head     = mem[rptr];
    ts_valid = (cnt != '0);
    ts_ns    = ts_valid ? head.ns  : '0;
    ts_sec   = ts_valid ? head.sec : '0;
    ts_cnt   = cnt;
    ts_ovf   = ovf;
  end

endmodule
